nano_boot_seq: RTL
==================

Name: nano_boot_seq

Overview:
Boot/run/dump sequencer for the NanoCPU and its 256x16 memory. It sits between the CPU bus and the memory. It holds the CPU in reset while loading a program image from a byte stream into memory at address 0, then runs the CPU for a bounded time. Afterwards it reads back a result window and streams it out as bytes. It owns the memory bus in every state except RUN, where the CPU bus passes through.

Parameters:
RUN_CYCLES, 150, maximum cycles in RUN before forced stop (1..65535)
DUMP_BASE, 15, first memory address of the result window
DUMP_LEN, 10, number of 16-bit words dumped (0..256)

Ports:
ck  in  1  clock, all state changes on rising edge
rst  in  1  asynchronous reset, active-low (asserted at 0)
start  in  1  begin a load/run/dump sequence (sampled in IDLE and DONE)
in_data  in  8  load byte stream data
in_valid  in  1  load byte valid
in_ready  out  1  load byte accepted when in_valid and in_ready are both 1
out_data  out  8  dump byte stream data
out_valid  out  1  dump byte valid
out_ready  in  1  dump consumer ready
cpu_halt  in  1  early-stop request, sampled only in RUN
cpu_rst  out  1  CPU reset, active-high, registered
cpu_address  in  8  CPU bus address
cpu_dataW  in  16  CPU write data
cpu_we  in  1  CPU write enable
cpu_ce  in  1  CPU chip enable
cpu_dataR  out  16  equals mem_dataR at all times
mem_address  out  8  memory address
mem_dataW  out  16  memory write data
mem_we  out  1  memory write enable; memory writes on the rising edge
mem_ce  out  1  memory chip enable
mem_dataR  in  16  memory read data, combinational (asynchronous read)
busy  out  1  1 in any state except IDLE and DONE
done  out  1  1 in DONE

Behaviour:
- States: IDLE, LOAD_HDR, LOAD_HI, LOAD_LO, RUN, DUMP_RD, DUMP_HI, DUMP_LO, DONE.
- Reset (rst=0, async) puts the block in IDLE and clears all counters and registers.
  - Reset values: cpu_rst=1, in_ready=0, out_valid=0, out_data=0, mem_we=0, mem_ce=0, mem_address=0, mem_dataW=0, busy=0, done=0.
- IDLE/DONE: when start=1, the next state is LOAD_HDR. While start=0, the state holds.
- LOAD_* states: in_ready=1. All handshakes below are in_valid and in_ready both 1.
  - LOAD_HDR: the accepted byte N is the word count. N=0 means no words and the next state is RUN. Otherwise wr_ptr=0, cnt=N, and the next state is LOAD_HI.
  - LOAD_HI: the accepted byte is stored in hi_reg, and the next state is LOAD_LO.
  - LOAD_LO: the write is issued in the same cycle as the handshake:
    - mem_we=1, mem_ce=1, mem_address=wr_ptr, mem_dataW={hi_reg,in_data}.
    - wr_ptr++ (8-bit).
    - After the N-th word the next state is RUN; otherwise LOAD_HI.
  - Without a handshake, a LOAD state holds and mem_we=0.
- RUN:
  - cpu_rst=0 registered, so it is 0 from the first RUN cycle. In every other state cpu_rst=1.
  - Bus pass-through: mem_address=cpu_address, mem_dataW=cpu_dataW, mem_we=cpu_we, mem_ce=cpu_ce.
  - run_cnt starts at 0 and increments every cycle.
  - Exit to DUMP_RD when cpu_halt=1 or run_cnt==RUN_CYCLES-1, whichever comes first. cpu_rst=1 from the next cycle.
  - If DUMP_LEN=0, exit goes to DONE instead.
- Outside RUN, CPU bus inputs are ignored; the CPU never reaches memory.
- Dump path, with idx starting at 0:
  - DUMP_RD: mem_ce=1, mem_we=0, mem_address=(DUMP_BASE+idx) mod 256. mem_dataR is captured into rd_reg, and the next state is DUMP_HI.
  - DUMP_HI: out_valid=1, out_data=rd_reg[15:8]. On out_ready the next state is DUMP_LO.
  - DUMP_LO: out_valid=1, out_data=rd_reg[7:0]. On out_ready: idx++, then DONE if idx was DUMP_LEN-1, else DUMP_RD.
- out_valid and out_data hold stable while out_ready=0. Minimum 3 cycles per dumped word.
- mem_we is never 1 outside LOAD_LO handshakes or RUN pass-through.
- Wrap-around: wr_ptr and dump addresses wrap modulo 256. N=255 writes addresses 0..254.
- start is ignored while busy=1.
- rst asserted mid-sequence aborts immediately. No further writes occur, and cpu_rst returns to 1 asynchronously.

Test Plan:
- Reset: hold rst=0 -> cpu_rst=1, busy=0, done=0, mem_we=0, out_valid=0, in_ready=0.
- Load: start, then bytes 03,40,00,41,11,F0,00 -> mem[0]=4000, mem[1]=4111, mem[2]=F000, each with exactly one mem_we pulse; cpu_rst falls on the cycle after the last byte.
- Run timeout: CPU program loops forever, RUN_CYCLES=150 -> exactly 150 cycles with cpu_rst=0, then the dump of mem[15..24] starts.
- Early halt: cpu_halt=1 at run cycle 20 -> cpu_rst=1 on the next cycle; the CPU writes 0x1234 to mem[15] before the halt -> first out bytes are 12, 34.
- Backpressure: out_ready toggles 1010... -> 20 bytes in order, none dropped or duplicated; out_data stable while stalled; done=1 after the last byte.
- Edge cases:
  - Header 00 -> RUN immediately, with no writes.
  - rst pulsed after 3 load bytes -> IDLE, memory beyond mem[0] untouched.
  - A new start from DONE repeats the full sequence.

Source files
------------

// File: rtl/nano_boot_seq.sv
// Boot/run/dump sequencer for NanoCPU: loads a program image into memory from a byte
// stream, runs the CPU for a bounded time, then streams a result window back out.
module nano_boot_seq #(
    parameter int RUN_CYCLES = 150,
    parameter int DUMP_BASE  = 15,
    parameter int DUMP_LEN   = 10
) (
    input  logic        ck,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    input  logic        cpu_halt,
    output logic        cpu_rst,
    input  logic [7:0]  cpu_address,
    input  logic [15:0] cpu_dataW,
    input  logic        cpu_we,
    input  logic        cpu_ce,
    output logic [15:0] cpu_dataR,
    output logic [7:0]  mem_address,
    output logic [15:0] mem_dataW,
    output logic        mem_we,
    output logic        mem_ce,
    input  logic [15:0] mem_dataR,
    output logic        busy,
    output logic        done
);

    localparam logic [15:0] RUN_LAST  = 16'(RUN_CYCLES - 1);
    localparam logic [8:0]  DUMP_LAST = 9'(DUMP_LEN - 1);
    localparam logic [7:0]  BASE8     = 8'(DUMP_BASE);

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD_HDR, S_LOAD_HI, S_LOAD_LO, S_RUN,
        S_DUMP_RD, S_DUMP_HI, S_DUMP_LO, S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  wr_ptr_q, wr_ptr_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  hi_q, hi_d;
    logic [15:0] run_cnt_q, run_cnt_d;
    logic [8:0]  idx_q, idx_d;
    logic [15:0] rd_q, rd_d;
    logic        cpu_rst_q;

    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            wr_ptr_q  <= '0;
            cnt_q     <= '0;
            hi_q      <= '0;
            run_cnt_q <= '0;
            idx_q     <= '0;
            rd_q      <= '0;
            cpu_rst_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            run_cnt_q <= run_cnt_d;
            idx_q     <= idx_d;
            rd_q      <= rd_d;
            // Registered so the CPU leaves reset exactly on the first RUN cycle.
            cpu_rst_q <= (state_d != S_RUN);
        end
    end

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        cnt_d       = cnt_q;
        hi_d        = hi_q;
        run_cnt_d   = '0;
        idx_d       = idx_q;
        rd_d        = rd_q;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        out_data    = 8'h00;
        mem_address = 8'h00;
        mem_dataW   = 16'h0000;
        mem_we      = 1'b0;
        mem_ce      = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) state_d = S_LOAD_HDR;
            end
            S_LOAD_HDR: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (in_data == 8'h00) begin
                        state_d = S_RUN;
                    end else begin
                        wr_ptr_d = 8'h00;
                        cnt_d    = in_data;
                        state_d  = S_LOAD_HI;
                    end
                end
            end
            S_LOAD_HI: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    hi_d    = in_data;
                    state_d = S_LOAD_LO;
                end
            end
            S_LOAD_LO: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    mem_we      = 1'b1;
                    mem_ce      = 1'b1;
                    mem_address = wr_ptr_q;
                    mem_dataW   = {hi_q, in_data};
                    wr_ptr_d    = wr_ptr_q + 8'd1;
                    cnt_d       = cnt_q - 8'd1;
                    state_d     = (cnt_q == 8'd1) ? S_RUN : S_LOAD_HI;
                end
            end
            S_RUN: begin
                mem_address = cpu_address;
                mem_dataW   = cpu_dataW;
                mem_we      = cpu_we;
                mem_ce      = cpu_ce;
                run_cnt_d   = run_cnt_q + 16'd1;
                idx_d       = '0;
                if (cpu_halt || run_cnt_q == RUN_LAST)
                    state_d = (DUMP_LEN == 0) ? S_DONE : S_DUMP_RD;
            end
            S_DUMP_RD: begin
                mem_ce      = 1'b1;
                mem_address = BASE8 + idx_q[7:0];
                rd_d        = mem_dataR;
                state_d     = S_DUMP_HI;
            end
            S_DUMP_HI: begin
                out_valid = 1'b1;
                out_data  = rd_q[15:8];
                if (out_ready) state_d = S_DUMP_LO;
            end
            S_DUMP_LO: begin
                out_valid = 1'b1;
                out_data  = rd_q[7:0];
                if (out_ready) begin
                    idx_d   = idx_q + 9'd1;
                    state_d = (idx_q == DUMP_LAST) ? S_DONE : S_DUMP_RD;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign cpu_rst   = cpu_rst_q;
    assign cpu_dataR = mem_dataR;
    assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done      = (state_q == S_DONE);

endmodule
